mult_cell_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined 32x32->32 multiply cell (low 32 bits of the unsigned product, fixed pipeline latency) between several requesters. It takes in operand pairs with a valid/ready handshake and issues at most one pair per cycle to the cell. It tracks each in-flight operation with a tag pipeline and returns each result to the requester that issued it. The block sits between the custom-instruction/accelerator masters and the shared multiply cell, so only one hardware multiplier is needed.

---
 rtl/mult_arb_pkg.sv | 33 +++
 rtl/mult_cell_arbiter_rr_arbiter.sv | 32 +++
 rtl/mult_cell_arbiter.sv | 94 +++++++++
 tb/tb_mult_cell_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiply-cell arbiter.
// Tags carry requester ids through the cell pipeline.
package mult_arb_pkg;

  localparam int MUL_W    = 32;
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } mult_tag_t;

  // Returns {found, index}, searching from last+1 upward, modulo n.
  function automatic logic [MAX_ID_W:0] rr_pick(
    input logic [MAX_REQ-1:0]  req,
    input logic [MAX_ID_W-1:0] last,
    input int                  n
  );
    logic [MAX_ID_W:0] res;
    int                idx;
    res = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !res[MAX_ID_W] &&
          req[idx[MAX_ID_W-1:0]]) begin
        res = {1'b1, idx[MAX_ID_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_cell_arbiter_rr_arbiter.sv
// Combinational round-robin grant selection.
// Grants the first request after the pointer.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_vld
);

  logic [MAX_REQ-1:0]  req_ext;
  logic [MAX_ID_W-1:0] ptr_ext;
  logic [MAX_ID_W:0]   pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    ptr_ext                = '0;
    ptr_ext[ID_W-1:0]      = last_grant;
    pick      = rr_pick(req_ext, ptr_ext, NUM_REQ);
    grant_vld = pick[MAX_ID_W];
    grant_id  = pick[ID_W-1:0];
    grant     = '0;
    if (grant_vld) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/mult_cell_arbiter.sv
// Shares one pipelined multiply cell among NUM_REQ requesters.
// A tag pipeline routes each product back to its issuer.
module mult_cell_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MUL_W-1:0] req_src1,
  input  logic [NUM_REQ*MUL_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [MUL_W-1:0]         rsp_result,
  output logic [MUL_W-1:0]         cell_src1,
  output logic [MUL_W-1:0]         cell_src2,
  input  logic [MUL_W-1:0]         cell_result,
  input  logic                     drain,
  output logic                     idle
);

  logic [ID_W-1:0]    last_grant;
  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               transfer;
  logic               any_vld;
  mult_tag_t          tags [LATENCY];
  mult_tag_t          fin;

  // Reset and drain both suppress new grants.
  assign req_eff = (reset_n && !drain) ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req       (req_eff),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (transfer)
  );

  assign req_ready = grant;

  always_comb begin
    cell_src1 = '0;
    cell_src2 = '0;
    if (transfer) begin
      cell_src1 = req_src1[MUL_W*grant_id +: MUL_W];
      cell_src2 = req_src2[MUL_W*grant_id +: MUL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      for (int i = 0; i < LATENCY; i++) begin
        tags[i] <= '0;
      end
    end else begin
      if (transfer) last_grant <= grant_id;
      tags[0] <= '{vld: transfer, id: MAX_ID_W'(grant_id)};
      for (int i = 1; i < LATENCY; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  assign fin = tags[LATENCY-1];

  always_comb begin
    rsp_valid  = '0;
    rsp_result = '0;
    if (reset_n && fin.vld) begin
      rsp_valid[fin.id[ID_W-1:0]] = 1'b1;
      rsp_result = cell_result;
    end
  end

  always_comb begin
    any_vld = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      any_vld = any_vld | tags[i].vld;
    end
  end

  assign idle = !reset_n || (!transfer && !any_vld);

endmodule

// File: tb/tb_mult_cell_arbiter.sv
// Directed bench for mult_cell_arbiter at latencies 1, 2 and 3.
// Three instances share stimulus; each test checks one of them.
module tb_mult_cell_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   req_valid;
  logic [127:0] req_src1;
  logic [127:0] req_src2;
  logic         drain;

  logic [3:0]  rdy1, rdy2, rdy3;
  logic [3:0]  rv1, rv2, rv3;
  logic [31:0] res1, res2, res3;
  logic [31:0] a1, a2, a3, b1, b2, b3;
  logic [31:0] cr1, cr2, cr3;
  logic        idle1, idle2, idle3;

  logic [31:0] p1, p2a, p2b, p3a, p3b, p3c;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1  <= a1 * b1;
    p2a <= a2 * b2;
    p2b <= p2a;
    p3a <= a3 * b3;
    p3b <= p3a;
    p3c <= p3b;
  end
  assign cr1 = p1;
  assign cr2 = p2b;
  assign cr3 = p3c;

  mult_cell_arbiter #(.NUM_REQ(4), .LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_ready(rdy1), .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rv1), .rsp_result(res1), .cell_src1(a1),
    .cell_src2(b1), .cell_result(cr1), .drain(drain), .idle(idle1)
  );

  mult_cell_arbiter #(.NUM_REQ(4), .LATENCY(2)) u2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_ready(rdy2), .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rv2), .rsp_result(res2), .cell_src1(a2),
    .cell_src2(b2), .cell_result(cr2), .drain(drain), .idle(idle2)
  );

  mult_cell_arbiter #(.NUM_REQ(4), .LATENCY(3)) u3 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid),
    .req_ready(rdy3), .req_src1(req_src1), .req_src2(req_src2),
    .rsp_valid(rv3), .rsp_result(res3), .cell_src1(a3),
    .cell_src2(b3), .cell_result(cr3), .drain(drain), .idle(idle3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    drain     = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic load_srcs();
    req_src1[31:0]   = 32'h0001_0000;
    req_src2[31:0]   = 32'h0001_0000;
    req_src1[63:32]  = 32'h0000_FFFF;
    req_src2[63:32]  = 32'h0000_FFFF;
    req_src1[95:64]  = 32'd6;
    req_src2[95:64]  = 32'd7;
    req_src1[127:96] = 32'h1234_5678;
    req_src2[127:96] = 32'd16;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    drain     = 1'b0;
    req_valid = 4'b1111;
    load_srcs();
    #1;
    n_total++;
    if (rdy1 !== 4'b0000)
      $display("FAIL reset_ready got=%b want=0000", rdy1);
    else n_pass++;
    n_total++;
    if (a1 !== 32'd0)
      $display("FAIL reset_cell_src1 got=%h want=0", a1);
    else n_pass++;
    n_total++;
    if (idle1 !== 1'b1)
      $display("FAIL reset_idle got=%b want=1", idle1);
    else n_pass++;
    tick();
    n_total++;
    if (rv1 !== 4'b0000 || res1 !== 32'd0)
      $display("FAIL reset_rsp got=%b/%h want=0000/0", rv1, res1);
    else n_pass++;
    reset_n   = 1'b1;
    req_valid = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_src1[31:0] = 32'd3;
    req_src2[31:0] = 32'd5;
    req_valid      = 4'b0001;
    #1;
    n_total++;
    if (rdy1 !== 4'b0001)
      $display("FAIL single_ready got=%b want=0001", rdy1);
    else n_pass++;
    n_total++;
    if (a1 !== 32'd3 || b1 !== 32'd5)
      $display("FAIL single_cell got=%h/%h want=3/5", a1, b1);
    else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_total++;
    if (rv1 !== 4'b0001 || res1 !== 32'd15)
      $display("FAIL single_rsp got=%b/%0d want=0001/15", rv1, res1);
    else n_pass++;
    n_total++;
    if (idle1 !== 1'b0)
      $display("FAIL single_busy got=%b want=0", idle1);
    else n_pass++;
    tick();
    n_total++;
    if (idle1 !== 1'b1 || rv1 !== 4'b0000)
      $display("FAIL single_idle got=%b/%b want=1/0000", idle1, rv1);
    else n_pass++;
  endtask

  task automatic test_all_rr();
    logic [31:0] exp_p [4];
    exp_p[0] = 32'h0000_0000;
    exp_p[1] = 32'hFFFE_0001;
    exp_p[2] = 32'd42;
    exp_p[3] = 32'h2345_6780;
    do_reset();
    load_srcs();
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_total++;
      if (rdy1 !== (4'b0001 << (i % 4)))
        $display("FAIL rr_grant_%0d got=%b want=%b",
                 i, rdy1, 4'b0001 << (i % 4));
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (rv1 !== (4'b0001 << ((i-1) % 4)) ||
            res1 !== exp_p[(i-1) % 4])
          $display("FAIL rr_rsp_%0d got=%b/%h want=%b/%h", i, rv1,
                   res1, 4'b0001 << ((i-1) % 4), exp_p[(i-1) % 4]);
        else n_pass++;
      end
      tick();
    end
    req_valid = '0;
    #1;
    n_total++;
    if (rv1 !== 4'b1000 || res1 !== exp_p[3])
      $display("FAIL rr_rsp_last got=%b/%h want=1000/%h",
               rv1, res1, exp_p[3]);
    else n_pass++;
    tick();
  endtask

  task automatic test_sparse();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b0010;
    exp_g[1] = 4'b1000;
    exp_g[2] = 4'b0010;
    do_reset();
    load_srcs();
    req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (rdy1 !== exp_g[i])
        $display("FAIL sparse_grant_%0d got=%b want=%b",
                 i, rdy1, exp_g[i]);
      else n_pass++;
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    load_srcs();
    req_valid = 4'b1111;
    #1;
    n_total++;
    if (rdy1 !== 4'b0001)
      $display("FAIL drain_g0 got=%b want=0001", rdy1);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (rdy1 !== 4'b0010)
      $display("FAIL drain_g1 got=%b want=0010", rdy1);
    else n_pass++;
    n_total++;
    if (rv1 !== 4'b0001 || res1 !== 32'd0)
      $display("FAIL drain_rsp0 got=%b/%h want=0001/0", rv1, res1);
    else n_pass++;
    tick();
    drain = 1'b1;
    #1;
    n_total++;
    if (rdy1 !== 4'b0000 || a1 !== 32'd0)
      $display("FAIL drain_stop got=%b/%h want=0000/0", rdy1, a1);
    else n_pass++;
    n_total++;
    if (rv1 !== 4'b0010 || res1 !== 32'hFFFE_0001)
      $display("FAIL drain_rsp1 got=%b/%h want=0010/fffe0001",
               rv1, res1);
    else n_pass++;
    n_total++;
    if (idle1 !== 1'b0)
      $display("FAIL drain_busy got=%b want=0", idle1);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if (rdy1 !== 4'b0000 || rv1 !== 4'b0000 || idle1 !== 1'b1)
      $display("FAIL drain_idle got=%b/%b/%b want=0000/0000/1",
               rdy1, rv1, idle1);
    else n_pass++;
    drain     = 1'b0;
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_src1[63:32] = 32'd4;
    req_src2[63:32] = 32'd4;
    req_valid       = 4'b0010;
    #1;
    n_total++;
    if (rdy2 !== 4'b0010)
      $display("FAIL rmid_grant got=%b want=0010", rdy2);
    else n_pass++;
    tick();
    reset_n   = 1'b0;
    req_valid = 4'b0011;
    #1;
    n_total++;
    if (rdy2 !== 4'b0000 || idle2 !== 1'b1 || rv2 !== 4'b0000)
      $display("FAIL rmid_in_reset got=%b/%b/%b want=0000/1/0000",
               rdy2, idle2, rv2);
    else n_pass++;
    tick();
    reset_n = 1'b1;
    #1;
    n_total++;
    if (rv2 !== 4'b0000 || res2 !== 32'd0)
      $display("FAIL rmid_no_rsp got=%b/%h want=0000/0", rv2, res2);
    else n_pass++;
    n_total++;
    if (rdy2 !== 4'b0001)
      $display("FAIL rmid_regrant got=%b want=0001", rdy2);
    else n_pass++;
    tick();
    req_valid = '0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c < 5) begin
        req_valid       = 4'b0100;
        req_src1[95:64] = 32'(c);
        req_src2[95:64] = 32'd7;
      end else begin
        req_valid = '0;
      end
      #1;
      if (c < 5) begin
        n_total++;
        if (rdy3 !== 4'b0100)
          $display("FAIL b2b_grant_%0d got=%b want=0100", c, rdy3);
        else n_pass++;
      end
      n_total++;
      if (c >= 3 && c < 8) begin
        if (rv3 !== 4'b0100 || res3 !== 32'(7 * (c - 3)))
          $display("FAIL b2b_rsp_%0d got=%b/%0d want=0100/%0d",
                   c, rv3, res3, 7 * (c - 3));
        else n_pass++;
      end else begin
        if (rv3 !== 4'b0000)
          $display("FAIL b2b_quiet_%0d got=%b want=0000", c, rv3);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_src1  = '0;
    req_src2  = '0;
    drain     = 1'b0;
    tick();
    test_reset();
    test_single();
    test_all_rr();
    test_sparse();
    test_drain();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
